// File: rtl/mdu_unit_if.sv
// Handshake/data bundle between the E stage and the multiply/divide unit.
interface mdu_unit_if;
  logic [2:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side: issues ops and reads HI/LO.
  modport master (
    output mdu_op, a, b, flush,
    input  start, busy, hi, lo
  );

  // Unit side.
  modport slave (
    input  mdu_op, a, b, flush,
    output start, busy, hi, lo
  );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed from the latched operands on the completing edge.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_unit_if.slave   bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               is_muldiv;
  logic               busy;
  logic               start;
  logic               res_wr;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;

  assign busy      = (state_q == RUN);
  assign is_muldiv = (bus.mdu_op >= OP_MULT) && (bus.mdu_op <= OP_DIVU);
  assign start     = is_muldiv && !bus.flush && !busy;

  assign bus.start = start;
  assign bus.busy  = busy;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // Result datapath from the latched operands; divide-by-zero suppresses the write.
  always_comb begin
    logic [63:0] prod;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    res_wr = 1'b0;
    res_hi = hi_q;
    res_lo = lo_q;
    prod   = '0;
    abs_a  = a_q[31] ? -a_q : a_q;
    abs_b  = b_q[31] ? -b_q : b_q;
    div_b  = (b_q == 32'd0) ? 32'd1 : b_q;
    q_mag  = '0;
    r_mag  = '0;
    unique case (op_q)
      OP_MULT: begin
        prod   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        res_wr = 1'b1;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      OP_MULTU: begin
        prod   = {32'd0, a_q} * {32'd0, b_q};
        res_wr = 1'b1;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      OP_DIV: begin
        // Magnitude divide keeps 0x80000000 / -1 well defined.
        q_mag  = abs_a / ((abs_b == 32'd0) ? 32'd1 : abs_b);
        r_mag  = abs_a % ((abs_b == 32'd0) ? 32'd1 : abs_b);
        res_wr = (b_q != 32'd0);
        res_lo = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
        res_hi = a_q[31] ? -r_mag : r_mag;
      end
      OP_DIVU: begin
        res_wr = (b_q != 32'd0);
        res_lo = a_q / div_b;
        res_hi = a_q % div_b;
      end
      default: ;
    endcase
  end

  // Next-state: accept ops in IDLE, count down in RUN, commit on the last edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.mdu_op;
          cnt_d   = (bus.mdu_op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          state_d = RUN;
        end else if (!bus.flush) begin
          if (bus.mdu_op == OP_MTHI) hi_d = bus.a;
          if (bus.mdu_op == OP_MTLO) lo_d = bus.a;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (res_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and HI/LO registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // The stall logic must hold every HI/LO-touching op while busy.
  a_no_op_while_busy : assert property (@(posedge clk) disable iff (reset)
    !(busy && (bus.mdu_op >= OP_MULT) && (bus.mdu_op <= OP_MTLO)));

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: expected HI/LO queued at issue, popped at completion.
module tb_mdu_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] sb[$];

  mdu_unit_if bus ();

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model written with native SV integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa;
    longint sb_v;
    int     ia;
    int     ib;
    model = {h, l};
    case (op)
      3'd1: begin
        sa    = longint'($signed(a));
        sb_v  = longint'($signed(b));
        model = 64'(sa * sb_v);
      end
      3'd2: model = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) model = {h, l};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
        else begin
          ia    = $signed(a);
          ib    = $signed(b);
          model = {32'(ia % ib), 32'(ia / ib)};
        end
      end
      3'd4: if (b != 32'd0) model = {a % b, a / b};
      default: ;
    endcase
  endfunction

  // Issue a mult/div, count busy cycles, then compare against the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cyc, input int flush_cyc);
    int n;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    logic [63:0] exp;
    prev_hi = m_hi;
    prev_lo = m_lo;
    @(negedge clk);
    bus.mdu_op = op; bus.a = a; bus.b = b; bus.flush = 1'b0;
    #1 chk({tag, "_start"}, 32'(bus.start), 32'd1);
    exp = model(op, a, b, m_hi, m_lo);
    sb.push_back(exp);
    {m_hi, m_lo} = exp;
    @(negedge clk);
    bus.mdu_op = 3'd0;
    n = 0;
    while (bus.busy && n < 200) begin
      if (n == 2) begin
        chk({tag, "_hi_stable"}, bus.hi, prev_hi);
        chk({tag, "_lo_stable"}, bus.lo, prev_lo);
      end
      bus.flush = (n == flush_cyc);
      n++;
      @(negedge clk);
    end
    bus.flush = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(cyc));
    if (sb.size() == 0) chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    else begin
      exp = sb.pop_front();
      chk({tag, "_hi"}, bus.hi, exp[63:32]);
      chk({tag, "_lo"}, bus.lo, exp[31:0]);
    end
  endtask

  // mthi/mtlo (or a flushed op): single cycle, busy must stay low.
  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic fl);
    @(negedge clk);
    bus.mdu_op = op; bus.a = a; bus.b = 32'd0; bus.flush = fl;
    #1 chk({tag, "_start"}, 32'(bus.start), 32'd0);
    if (!fl && op == 3'd5) m_hi = a;
    if (!fl && op == 3'd6) m_lo = a;
    @(negedge clk);
    bus.mdu_op = 3'd0; bus.flush = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hi"}, bus.hi, m_hi);
    chk({tag, "_lo"}, bus.lo, m_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    bus.mdu_op = 3'd0; bus.a = 32'd0; bus.b = 32'd0; bus.flush = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, -1);
    chk("mult_neg_hi_const", bus.hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo_const", bus.lo, 32'hFFFF_FFFA);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, -1);
    chk("multu_hi_const", bus.hi, 32'hFFFF_FFFE);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, -1);
    chk("div_neg_lo_const", bus.lo, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, -1);
    chk("div_ovf_lo_const", bus.lo, 32'h8000_0000);
    single("mthi", 3'd5, 32'h11, 1'b0);
    single("mtlo", 3'd6, 32'h22, 1'b0);
    run_op("divu_zero", 3'd4, 32'd1234, 32'd0, 10, -1);
    chk("divu_zero_hi_const", bus.hi, 32'h11);
    run_op("divu", 3'd4, 32'd1000, 32'd7, 10, -1);
    run_op("mult_rand", 3'd1, $urandom, $urandom, 5, -1);
    run_op("div_rand", 3'd3, $urandom, $urandom_range(1, 1000), 10, -1);

    single("flush_mult", 3'd1, 32'd9, 1'b1);
    single("flush_mthi", 3'd5, 32'hDEAD, 1'b1);
    run_op("div_flush_run", 3'd3, 32'd100, 32'd7, 10, 3);
    chk("div_flush_lo_const", bus.lo, 32'd14);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.mdu_op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
    sb.push_back(model(3'd3, 32'd100, 32'd7, m_hi, m_lo));
    @(negedge clk);
    bus.mdu_op = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    sb.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_hi", bus.hi, 32'd0);
    chk("rst_mid_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_hi", bus.hi, 32'd0);
    chk("post_rst_lo", bus.lo, 32'd0);
    run_op("mult_after_rst", 3'd1, 32'd6, 32'd7, 5, -1);
    chk("mult_after_rst_lo_const", bus.lo, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult, multu, div, divu, mthi and mtlo.
- Exposes start and busy; the stall logic combines these with the D-stage is_mf_D flag to hold any HI/LO-touching instruction in D while an operation is outstanding.
- Results are read by mfhi/mflo in E through the hi/lo outputs.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
mdu_op  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
a  input  32  forwarded rs value in E
b  input  32  forwarded rt value in E
flush  input  1  exception/interrupt taken this cycle; suppresses acceptance of mdu_op
start  output  1  combinational: mdu_op in {1..4} && !flush && !busy
busy  output  1  registered: an operation is in progress
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (asynchronous, any time, including mid-operation): busy=0, counter=0, hi=0, lo=0, latched operands and op cleared. No partial result is ever written.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter>0).
- IDLE, at a rising edge with start=1:
  - latch a, b and the op;
  - load counter with MULT_CYCLES for ops 1/2 or DIV_CYCLES for ops 3/4;
  - set busy=1.
- RUN, each edge: counter decrements.
- Completion: on the edge where counter goes 1->0, busy falls and hi/lo are written in the same edge. The result is visible from the first cycle with busy=0.
- Total: busy is high for exactly N cycles after the start edge.
- mthi/mtlo, at an edge with !flush && !busy:
  - mthi writes hi<=a; mtlo writes lo<=a;
  - busy never asserts.
- mdu_op accepted while busy=1: ignored. The stall logic guarantees it does not occur.
- Assertion: mdu_op in {1..6} && busy must never happen.
- flush=1:
  - blocks start and mt writes in that cycle;
  - does NOT cancel an operation already in RUN, because it was committed by an older instruction.
- mult: {hi,lo} = signed 64-bit product of a*b.
- multu: {hi,lo} = unsigned 64-bit product of a*b.
- div:
  - lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient in lo, unsigned remainder in hi.
- Divide by zero (b==0):
  - the busy sequence still runs the full DIV_CYCLES;
  - hi and lo keep their previous values at completion.
- Arithmetic may be computed combinationally from the latched operands at completion or staged internally. Only the externally visible timing above is normative.
- hi/lo are stable throughout RUN; mfhi/mflo are stalled upstream anyway.
- Back-to-back: a new start is accepted on the first edge with busy=0, i.e. the cycle immediately after completion.

Test Plan:
1. reset; mdu_op=1, a=0xFFFFFFFE (-2), b=3, one cycle -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. mdu_op=2, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
3. mdu_op=3, a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
4. mdu_op=3, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then mdu_op=4, b=0 with hi/lo=0x11/0x22 preset by mthi/mtlo -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
5. Apply mdu_op=1 with flush=1 -> start=0, busy stays 0, hi/lo unchanged. Apply mdu_op=5 with flush=1 -> hi unchanged. Then start a div and raise flush during RUN -> the division completes normally.
6. Start div (a=100, b=7); assert reset after 4 busy cycles -> busy=0, hi=lo=0 immediately (asynchronously). After release no write occurs. Next mult (a=6, b=7) gives lo=42 after 5 cycles.
